// File: rtl/ysyx_23060124_ifu.sv
// Instruction fetch unit: owns the PC, issues one fetch at a time to instruction
// memory, holds the returned word for decode and honours redirects from execute.
// Optional performance counters are enabled with `define YSYX_23060124_IFU_PERF_EN.
module ysyx_23060124_ifu #(
   parameter int unsigned          ISA_WIDTH = 32,
   parameter logic [ISA_WIDTH-1:0] RESET_PC  = 32'h8000_0000
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   output logic                 o_imem_req_valid,
   input  logic                 i_imem_req_ready,
   output logic [ISA_WIDTH-1:0] o_imem_addr,
   input  logic                 i_imem_rsp_valid,
   input  logic [ISA_WIDTH-1:0] i_imem_rsp_data,
   input  logic                 i_imem_rsp_err,
   output logic [ISA_WIDTH-1:0] o_ins,
   output logic [ISA_WIDTH-1:0] o_pc,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic                 o_fetch_err,
   input  logic                 i_redirect_valid,
   input  logic [ISA_WIDTH-1:0] i_redirect_pc
`ifdef YSYX_23060124_IFU_PERF_EN
   ,
   output logic [63:0]          o_perf_fetch_cnt,
   output logic [63:0]          o_perf_stall_cnt
`endif
);

   typedef enum logic [1:0] {StReq = 2'd0, StWait = 2'd1, StHold = 2'd2} state_e;

   state_e               state_q, state_d;
   logic [ISA_WIDTH-1:0] pc_q, pc_d;
   logic                 kill_q, kill_d;
   logic                 valid_q, valid_d;
   logic [ISA_WIDTH-1:0] ins_q, ins_d;
   logic [ISA_WIDTH-1:0] opc_q, opc_d;
   logic                 err_q, err_d;
   logic                 misaligned;
   logic                 req_fire;

   assign misaligned       = (pc_q[1:0] != 2'b00);
   // A misaligned PC never reaches the bus; it is reported straight to decode.
   assign o_imem_req_valid = (state_q == StReq) && !i_rst && !misaligned;
   assign o_imem_addr      = pc_q;
   assign req_fire         = o_imem_req_valid && i_imem_req_ready;

   assign o_ins       = ins_q;
   assign o_pc        = opc_q;
   assign o_valid     = valid_q;
   assign o_fetch_err = err_q;

   // Next-state logic: redirect outranks everything except reset.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      kill_d  = kill_q;
      valid_d = valid_q;
      ins_d   = ins_q;
      opc_d   = opc_q;
      err_d   = err_q;
      if (i_redirect_valid) begin
         pc_d = i_redirect_pc;
      end
      case (state_q)
         StReq: begin
            if (i_redirect_valid) begin
               // An accepted request now carries a stale address; drop its response.
               if (req_fire) begin
                  state_d = StWait;
                  kill_d  = 1'b1;
               end
            end else if (misaligned) begin
               state_d = StHold;
               valid_d = 1'b1;
               ins_d   = '0;
               opc_d   = pc_q;
               err_d   = 1'b1;
            end else if (req_fire) begin
               state_d = StWait;
            end
         end
         StWait: begin
            if (i_imem_rsp_valid) begin
               if (i_redirect_valid || kill_q) begin
                  state_d = StReq;
                  kill_d  = 1'b0;
               end else begin
                  state_d = StHold;
                  valid_d = 1'b1;
                  ins_d   = i_imem_rsp_err ? '0 : i_imem_rsp_data;
                  opc_d   = pc_q;
                  err_d   = i_imem_rsp_err;
               end
            end else if (i_redirect_valid) begin
               kill_d = 1'b1;
            end
         end
         StHold: begin
            if (i_redirect_valid) begin
               state_d = StReq;
               valid_d = 1'b0;
            end else if (i_ready) begin
               state_d = StReq;
               valid_d = 1'b0;
               pc_d    = pc_q + ISA_WIDTH'(4);
            end
         end
         default: begin
            state_d = StReq;
         end
      endcase
   end

   // State register with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= StReq;
         pc_q    <= RESET_PC;
         kill_q  <= 1'b0;
         valid_q <= 1'b0;
         ins_q   <= '0;
         opc_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         kill_q  <= kill_d;
         valid_q <= valid_d;
         ins_q   <= ins_d;
         opc_q   <= opc_d;
         err_q   <= err_d;
      end
   end

`ifdef YSYX_23060124_IFU_PERF_EN
   logic [63:0] fetch_cnt_q;
   logic [63:0] stall_cnt_q;

   // Count delivered instructions and cycles spent waiting on memory.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (valid_q && i_ready) begin
            fetch_cnt_q <= fetch_cnt_q + 64'd1;
         end
         if (((state_q == StReq) && !i_imem_req_ready) || (state_q == StWait)) begin
            stall_cnt_q <= stall_cnt_q + 64'd1;
         end
      end
   end

   assign o_perf_fetch_cnt = fetch_cnt_q;
   assign o_perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ysyx_23060124_ifu.sv
// Self-checking bench for ysyx_23060124_ifu: directed scenarios plus a randomized
// run against a transaction-level PC/memory reference model.
module tb_ysyx_23060124_ifu;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_ready = 1'b0;
   logic        rsp_valid = 1'b0;
   logic        rsp_err = 1'b0;
   logic [31:0] rsp_data = '0;
   logic        rdy = 1'b0;
   logic        redir_valid = 1'b0;
   logic [31:0] redir_pc = '0;

   logic        req_valid;
   logic [31:0] imem_addr;
   logic [31:0] ins;
   logic [31:0] pc;
   logic        valid;
   logic        fetch_err;
`ifdef YSYX_23060124_IFU_PERF_EN
   logic [63:0] perf_fetch;
   logic [63:0] perf_stall;
`endif

   int checks = 0;
   int errors = 0;

   ysyx_23060124_ifu dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .o_imem_req_valid (req_valid),
      .i_imem_req_ready (req_ready),
      .o_imem_addr      (imem_addr),
      .i_imem_rsp_valid (rsp_valid),
      .i_imem_rsp_data  (rsp_data),
      .i_imem_rsp_err   (rsp_err),
      .o_ins            (ins),
      .o_pc             (pc),
      .o_valid          (valid),
      .i_ready          (rdy),
      .o_fetch_err      (fetch_err),
      .i_redirect_valid (redir_valid),
      .i_redirect_pc    (redir_pc)
`ifdef YSYX_23060124_IFU_PERF_EN
      ,
      .o_perf_fetch_cnt (perf_fetch),
      .o_perf_stall_cnt (perf_stall)
`endif
   );

   always #5 clk = ~clk;

   // Memory contents and error map used by the random test.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
   endfunction

   function automatic logic mem_err(input logic [31:0] a);
      return (a[5:2] == 4'hb);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic consume();
      rdy = 1'b1;
      step();
      rdy = 1'b0;
   endtask

   // Wait for a request, accept it and answer one cycle later.
   task automatic do_fetch(input logic [31:0] data, input logic err, output logic [31:0] addr);
      int n = 0;
      while (!req_valid && n < 20) begin
         step();
         n++;
      end
      checks++;
      if (req_valid !== 1'b1) begin
         errors++;
         $display("FAIL fetch_req_timeout: req_valid=%b want 1", req_valid);
      end
      addr = imem_addr;
      req_ready = 1'b1;
      step();
      req_ready = 1'b0;
      rsp_valid = 1'b1;
      rsp_data  = data;
      rsp_err   = err;
      step();
      rsp_valid = 1'b0;
      rsp_err   = 1'b0;
      rsp_data  = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      checks++;
      if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
      checks++;
      if (ins !== 32'h0) begin errors++; $display("FAIL reset_ins: got %h want 0", ins); end
      checks++;
      if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", pc); end
      checks++;
      if (fetch_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", fetch_err); end
      checks++;
      if (req_valid !== 1'b0) begin
         errors++; $display("FAIL reset_req_valid: got %b want 0", req_valid);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (req_valid !== 1'b1 || imem_addr !== 32'h8000_0000) begin
         errors++;
         $display("FAIL reset_first_req: valid=%b addr=%h want 1 80000000", req_valid, imem_addr);
      end
   endtask

   task automatic test_basic();
      logic [31:0] a;
      do_fetch(32'h0000_0413, 1'b0, a);
      checks++;
      if (a !== 32'h8000_0000) begin errors++; $display("FAIL basic_addr0: got %h want 80000000", a); end
      checks++;
      if (valid !== 1'b1 || pc !== 32'h8000_0000 || ins !== 32'h0000_0413 || fetch_err !== 1'b0) begin
         errors++;
         $display("FAIL basic_deliver0: v=%b pc=%h ins=%h err=%b want 1 80000000 00000413 0",
                  valid, pc, ins, fetch_err);
      end
      consume();
      do_fetch(32'h0010_0093, 1'b0, a);
      checks++;
      if (a !== 32'h8000_0004) begin errors++; $display("FAIL basic_addr1: got %h want 80000004", a); end
      checks++;
      if (valid !== 1'b1 || pc !== 32'h8000_0004 || ins !== 32'h0010_0093) begin
         errors++;
         $display("FAIL basic_deliver1: v=%b pc=%h ins=%h want 1 80000004 00100093", valid, pc, ins);
      end
      consume();
   endtask

   task automatic test_stall();
      logic [31:0] a;
      do_fetch(32'h0020_8133, 1'b0, a);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (valid !== 1'b1 || pc !== 32'h8000_0008 || ins !== 32'h0020_8133 || req_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold[%0d]: v=%b pc=%h ins=%h req=%b want 1 80000008 00208133 0",
                     i, valid, pc, ins, req_valid);
         end
         step();
      end
      consume();
      checks++;
      if (req_valid !== 1'b1 || imem_addr !== 32'h8000_000c || valid !== 1'b0) begin
         errors++;
         $display("FAIL stall_next_req: req=%b addr=%h v=%b want 1 8000000c 0",
                  req_valid, imem_addr, valid);
      end
   endtask

   task automatic test_redirect_wait();
      logic [31:0] a;
      req_ready = 1'b1;
      step();
      req_ready = 1'b0;
      redir_valid = 1'b1;
      redir_pc    = 32'h8000_0100;
      step();
      redir_valid = 1'b0;
      checks++;
      if (valid !== 1'b0 || req_valid !== 1'b0) begin
         errors++; $display("FAIL redir_wait_idle: v=%b req=%b want 0 0", valid, req_valid);
      end
      step();
      rsp_valid = 1'b1;
      rsp_data  = 32'hdead_beef;
      step();
      rsp_valid = 1'b0;
      rsp_data  = '0;
      checks++;
      if (valid !== 1'b0 || ins === 32'hdead_beef) begin
         errors++; $display("FAIL redir_stale_dropped: v=%b ins=%h want 0 and not deadbeef", valid, ins);
      end
      checks++;
      if (req_valid !== 1'b1 || imem_addr !== 32'h8000_0100) begin
         errors++; $display("FAIL redir_new_req: req=%b addr=%h want 1 80000100", req_valid, imem_addr);
      end
      do_fetch(32'h0000_0513, 1'b0, a);
      checks++;
      if (valid !== 1'b1 || pc !== 32'h8000_0100 || ins !== 32'h0000_0513) begin
         errors++;
         $display("FAIL redir_deliver: v=%b pc=%h ins=%h want 1 80000100 00000513", valid, pc, ins);
      end
      consume();
   endtask

   task automatic test_misaligned();
      redir_valid = 1'b1;
      redir_pc    = 32'h8000_0202;
      step();
      redir_valid = 1'b0;
      checks++;
      if (req_valid !== 1'b0) begin errors++; $display("FAIL misal_no_req: got %b want 0", req_valid); end
      step();
      checks++;
      if (valid !== 1'b1 || fetch_err !== 1'b1 || ins !== 32'h0 || pc !== 32'h8000_0202
          || req_valid !== 1'b0) begin
         errors++;
         $display("FAIL misal_deliver: v=%b err=%b ins=%h pc=%h req=%b want 1 1 0 80000202 0",
                  valid, fetch_err, ins, pc, req_valid);
      end
      redir_valid = 1'b1;
      redir_pc    = 32'h8000_0300;
      step();
      redir_valid = 1'b0;
      checks++;
      if (valid !== 1'b0 || req_valid !== 1'b1 || imem_addr !== 32'h8000_0300) begin
         errors++;
         $display("FAIL hold_redirect: v=%b req=%b addr=%h want 0 1 80000300", valid, req_valid, imem_addr);
      end
   endtask

   task automatic test_bus_err();
      logic [31:0] a;
      do_fetch(32'h1234_5678, 1'b1, a);
      checks++;
      if (a !== 32'h8000_0300 || valid !== 1'b1 || fetch_err !== 1'b1 || ins !== 32'h0
          || pc !== 32'h8000_0300) begin
         errors++;
         $display("FAIL bus_err: addr=%h v=%b err=%b ins=%h pc=%h want 80000300 1 1 0 80000300",
                  a, valid, fetch_err, ins, pc);
      end
      consume();
   endtask

   task automatic test_reset_in_wait();
      req_ready = 1'b1;
      step();
      req_ready = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      checks++;
      if (valid !== 1'b0 || req_valid !== 1'b1 || imem_addr !== 32'h8000_0000) begin
         errors++;
         $display("FAIL rst_wait: v=%b req=%b addr=%h want 0 1 80000000", valid, req_valid, imem_addr);
      end
      rsp_valid = 1'b1;
      rsp_data  = 32'habcd_ef01;
      step();
      rsp_valid = 1'b0;
      rsp_data  = '0;
      checks++;
      if (valid !== 1'b0 || ins !== 32'h0 || req_valid !== 1'b1 || imem_addr !== 32'h8000_0000) begin
         errors++;
         $display("FAIL rst_late_rsp: v=%b ins=%h req=%b addr=%h want 0 0 1 80000000",
                  valid, ins, req_valid, imem_addr);
      end
   endtask

   task automatic test_random();
      logic [31:0] exp_pc;
      logic [31:0] maddr = '0;
      logic        busy = 1'b0;
      logic        exp_e;
      logic [31:0] exp_i;
      int unsigned delay = 0;
      int          delivered = 0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_pc = 32'h8000_0000;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         req_ready   = ($urandom_range(0, 2) != 0);
         rdy         = 1'($urandom_range(0, 1));
         redir_valid = ($urandom_range(0, 9) == 0);
         redir_pc    = 32'h8000_0000 | (32'($urandom_range(0, 1023)) << 2)
                       | (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0);
         if (busy && delay == 0) begin
            rsp_valid = 1'b1;
            rsp_data  = mem_word(maddr);
            rsp_err   = mem_err(maddr);
         end else begin
            rsp_valid = 1'b0;
            rsp_data  = $urandom;
            rsp_err   = 1'($urandom_range(0, 1));
         end
         #1;
         if (valid) begin
            exp_e = (exp_pc[1:0] != 2'b00) || mem_err(exp_pc);
            exp_i = exp_e ? 32'h0 : mem_word(exp_pc);
            checks++;
            if (pc !== exp_pc || ins !== exp_i || fetch_err !== exp_e) begin
               errors++;
               $display("FAIL rand_deliver@%0d: pc=%h ins=%h err=%b want %h %h %b",
                        cyc, pc, ins, fetch_err, exp_pc, exp_i, exp_e);
            end
         end
         if (req_valid) begin
            checks++;
            if (imem_addr !== exp_pc || valid !== 1'b0 || exp_pc[1:0] != 2'b00) begin
               errors++;
               $display("FAIL rand_req@%0d: addr=%h v=%b want %h 0 (aligned)", cyc, imem_addr, valid, exp_pc);
            end
         end
         if (valid && rdy) delivered++;
         if (req_valid && req_ready) begin
            busy  = 1'b1;
            maddr = imem_addr;
            delay = $urandom_range(0, 2);
         end else if (rsp_valid) begin
            busy = 1'b0;
         end else if (busy) begin
            delay--;
         end
         if (redir_valid) exp_pc = redir_pc;
         else if (valid && rdy) exp_pc = exp_pc + 32'd4;
         step();
      end
      rsp_valid   = 1'b0;
      redir_valid = 1'b0;
      rdy         = 1'b0;
      req_ready   = 1'b0;
      checks++;
      if (delivered < 100) begin
         errors++; $display("FAIL rand_progress: delivered %0d want >= 100", delivered);
      end
`ifdef YSYX_23060124_IFU_PERF_EN
      checks++;
      if (perf_fetch !== 64'(delivered)) begin
         errors++; $display("FAIL perf_fetch: got %0d want %0d", perf_fetch, delivered);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_redirect_wait();
      test_misaligned();
      test_bus_err();
      test_reset_in_wait();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ysyx_23060124_ifu.md
Name: ysyx_23060124_ifu

Overview:
- Instruction fetch unit, directly upstream of the decode stage.
- Owns the architectural PC and issues one 32-bit fetch at a time to instruction memory over a valid/ready request and valid response channel.
- Holds the returned instruction and its PC, and presents them to decode with a valid/ready handshake.
- Accepts a redirect (taken branch, jal, jalr) from execute and discards any stale in-flight or held instruction.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- ISA_WIDTH, 32, instruction and address width.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- o_imem_req_valid  output  1  fetch request valid.
- i_imem_req_ready  input  1  memory accepts the request this cycle.
- o_imem_addr  output  ISA_WIDTH  fetch address; equals the current PC.
- i_imem_rsp_valid  input  1  response data valid.
- i_imem_rsp_data  input  ISA_WIDTH  fetched instruction word.
- i_imem_rsp_err  input  1  bus error for this response.
- o_ins  output  ISA_WIDTH  instruction to decode.
- o_pc  output  ISA_WIDTH  PC of o_ins.
- o_valid  output  1  o_ins/o_pc valid.
- i_ready  input  1  decode consumes o_ins this cycle.
- o_fetch_err  output  1  qualified by o_valid; the delivered instruction had a bus error or a misaligned PC.
- i_redirect_valid  input  1  redirect request from execute.
- i_redirect_pc  input  ISA_WIDTH  redirect target.

Behaviour:
Reset values (i_rst high at an edge):
- pc=RESET_PC, state=REQ, kill=0.
- o_valid=0, o_ins=0, o_pc=0, o_fetch_err=0.
- o_imem_req_valid=0 in the cycle reset is asserted. It is driven combinationally as state==REQ && !i_rst.
- Reset mid-operation abandons any in-flight request. A response arriving while kill=0 in REQ state is ignored.

States (2-bit):
- REQ:
  - o_imem_req_valid=1, o_imem_addr=pc.
  - On i_imem_req_ready, go to WAIT.
  - o_imem_addr must stay stable while valid && !ready, unless a redirect occurs.
- WAIT:
  - Waits for i_imem_rsp_valid.
  - On response with kill=0: latch o_ins=rsp_data, o_pc=pc, o_fetch_err=rsp_err, set o_valid=1, go to HOLD.
  - On response with kill=1: drop the data, clear kill, go to REQ.
- HOLD:
  - o_valid=1.
  - On i_ready: o_valid<=0, pc<=pc+4 (modulo 2^32, wraps), go to REQ.

Timing:
- Minimum latency from request accept to o_valid is 1 cycle after rsp_valid.
- Throughput is at most one instruction per 3 cycles; there is no prefetch.

Redirect (highest priority after reset):
- pc<=i_redirect_pc in every state.
- REQ, request not accepted this cycle: stay in REQ. The new address appears the next cycle.
- REQ with the handshake completing the same cycle: go to WAIT with kill=1.
- WAIT, no response this cycle: kill<=1, stay in WAIT.
- WAIT with a response the same cycle: drop the response, go to REQ, kill=0.
- HOLD, regardless of i_ready: o_valid<=0, go to REQ. pc is not incremented.

Misalignment:
- If pc[1:0]!=0 in REQ, no memory request is issued.
- The unit goes directly to HOLD with o_ins=0, o_pc=pc, o_fetch_err=1.
- o_ins=0 keeps decode's illegal-instruction reporting silent; trap handling keys off o_fetch_err.

Other rules:
- Bus error: o_ins is forced to 0 when i_imem_rsp_err=1.
- o_ins, o_pc and o_fetch_err are registered and change only when o_valid rises.

Optional Feature:
- Macro: YSYX_23060124_IFU_PERF_EN.
- When defined, adds outputs o_perf_fetch_cnt (64) and o_perf_stall_cnt (64), both reset to 0:
  - fetch_cnt increments on each o_valid && i_ready.
  - stall_cnt increments each cycle in REQ with !i_imem_req_ready, or in WAIT.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset then memory always ready, response 1 cycle later with 32'h00000413, i_ready=1 → first o_valid with o_pc=32'h80000000 and o_ins=32'h00000413; second o_pc=32'h80000004.
- Decode stalls, i_ready=0 for 5 cycles in HOLD → o_ins and o_pc stable, no new o_imem_req_valid; after i_ready the next request uses addr=pc+4.
- Redirect to 32'h80000100 while in WAIT, stale response 32'hdeadbeef arrives 2 cycles later → 32'hdeadbeef never appears on o_ins; the next request uses addr 32'h80000100.
- Redirect to 32'h80000202 → no request issued; o_valid=1, o_fetch_err=1, o_ins=0, o_pc=32'h80000202.
- Response with i_imem_rsp_err=1 → o_fetch_err=1, o_ins=0.
- Assert i_rst for 1 cycle in WAIT → next cycle pc=32'h80000000, o_valid=0, state REQ; a late response is ignored.
